// File: rtl/fighter_anim_ctrl_if.sv
// Per-fighter sequencer bus: video sync, player controls and collision in;
// sprite selection and position out to the renderers.
interface fighter_anim_ctrl_if;
  logic       vsync;
  logic       btn_left;
  logic       btn_right;
  logic       btn_punch;
  logic       btn_kick;
  logic       hit;
  logic [2:0] sprite_sel;
  logic [1:0] frame_idx;
  logic       facing_left;
  logic [9:0] RyuX;
  logic [9:0] RyuY;
  logic       busy;

  modport master (
    output vsync, btn_left, btn_right, btn_punch, btn_kick, hit,
    input  sprite_sel, frame_idx, facing_left, RyuX, RyuY, busy
  );

  modport slave (
    input  vsync, btn_left, btn_right, btn_punch, btn_kick, hit,
    output sprite_sel, frame_idx, facing_left, RyuX, RyuY, busy
  );
endinterface

// File: rtl/fighter_anim_ctrl.sv
// Frame-rate animation/motion sequencer: advances once per vsync falling edge
// and holds every sprite output stable for the rest of the field.
module fighter_anim_ctrl #(
  parameter int FRAME_DIV = 6,
  parameter int STEP      = 4,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 520,
  parameter int X_INIT    = 100,
  parameter int Y_GROUND  = 300
) (
  input  logic                 vga_clk,
  input  logic                 reset_n,
  fighter_anim_ctrl_if.slave   bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WALK  = 3'd1;
  localparam logic [2:0] S_PUNCH = 3'd2;
  localparam logic [2:0] S_KICK  = 3'd3;
  localparam logic [2:0] S_HIT   = 3'd4;

  localparam int              DIV_W     = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
  localparam logic [10:0]     LEFT_LIM  = 11'(X_MIN + STEP);
  localparam logic [10:0]     RIGHT_LIM = 11'(X_MAX - STEP);
  localparam logic [10:0]     STEP_W    = 11'(STEP);
  localparam logic [10:0]     XMIN_W    = 11'(X_MIN);
  localparam logic [10:0]     XMAX_W    = 11'(X_MAX);

  logic [2:0]       vs_q, vs_d;
  logic             hit_q, hit_d;
  logic [2:0]       state_q, state_d;
  logic [1:0]       frame_q, frame_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             facing_q, facing_d;
  logic [9:0]       x_q, x_d;

  logic       tick;
  logic       hit_pend;
  logic       busy;
  logic [1:0] last_frame;
  logic       seq_done;
  logic       walk_req;
  logic [10:0] x_ext;

  // vs_q[1] is the synchronized vsync, vs_q[2] its previous value
  assign tick     = vs_q[2] & ~vs_q[1];
  assign hit_pend = hit_q | bus.hit;
  assign busy     = (state_q == S_PUNCH) || (state_q == S_KICK) || (state_q == S_HIT);
  assign walk_req = bus.btn_left ^ bus.btn_right;
  assign x_ext    = {1'b0, x_q};

  always_comb begin
    case (state_q)
      S_PUNCH, S_KICK: last_frame = 2'd2;
      S_HIT:           last_frame = 2'd1;
      default:         last_frame = 2'd3;
    endcase
  end

  assign seq_done = busy && (frame_q == last_frame) && (div_q == DIV_LAST);

  always_comb begin
    logic       restart;
    logic       walking;
    logic [10:0] nx;
    vs_d     = {vs_q[1:0], bus.vsync};
    hit_d    = hit_pend;
    state_d  = state_q;
    frame_d  = frame_q;
    div_d    = div_q;
    facing_d = facing_q;
    x_d      = x_q;
    restart  = 1'b0;
    walking  = 1'b0;
    nx       = x_ext;

    if (tick) begin
      hit_d = 1'b0;
      if (hit_pend) begin
        state_d = S_HIT;
        restart = 1'b1;
      end else if (busy && !seq_done) begin
        state_d = state_q;
      end else begin
        if (bus.btn_punch)      state_d = S_PUNCH;
        else if (bus.btn_kick)  state_d = S_KICK;
        else if (walk_req)      state_d = S_WALK;
        else                    state_d = S_IDLE;
        walking = (state_d == S_WALK);
        // A finished one-shot chosen again replays from its first frame
        restart = (state_d != state_q) || busy;
      end

      if (restart) begin
        frame_d = 2'd0;
        div_d   = '0;
      end else if (div_q == DIV_LAST) begin
        div_d   = '0;
        frame_d = frame_q + 2'd1;
      end else begin
        div_d   = div_q + 1'b1;
      end

      if (walking) begin
        facing_d = bus.btn_left;
        if (bus.btn_left) nx = (x_ext < LEFT_LIM)  ? XMIN_W : x_ext - STEP_W;
        else              nx = (x_ext > RIGHT_LIM) ? XMAX_W : x_ext + STEP_W;
        x_d = nx[9:0];
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_q     <= 3'b111;
      hit_q    <= 1'b0;
      state_q  <= S_IDLE;
      frame_q  <= 2'd0;
      div_q    <= '0;
      facing_q <= 1'b0;
      x_q      <= 10'(X_INIT);
    end else begin
      vs_q     <= vs_d;
      hit_q    <= hit_d;
      state_q  <= state_d;
      frame_q  <= frame_d;
      div_q    <= div_d;
      facing_q <= facing_d;
      x_q      <= x_d;
    end
  end

  assign bus.sprite_sel  = state_q;
  assign bus.frame_idx   = frame_q;
  assign bus.facing_left = facing_q;
  assign bus.RyuX        = x_q;
  assign bus.RyuY        = 10'(Y_GROUND);
  assign bus.busy        = busy;

endmodule

// File: tb/tb_fighter_anim_ctrl.sv
// Directed bench for fighter_anim_ctrl: two instances differing only in X_INIT
// share all stimulus so both walk clamps are reached from off-grid positions.
module tb_fighter_anim_ctrl;
  logic vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic reset_n;
  logic vsync, bl, br, bp, bk, hit;

  fighter_anim_ctrl_if ifa ();
  fighter_anim_ctrl_if ifb ();

  assign ifa.vsync = vsync;  assign ifb.vsync = vsync;
  assign ifa.btn_left = bl;  assign ifb.btn_left = bl;
  assign ifa.btn_right = br; assign ifb.btn_right = br;
  assign ifa.btn_punch = bp; assign ifb.btn_punch = bp;
  assign ifa.btn_kick = bk;  assign ifb.btn_kick = bk;
  assign ifa.hit = hit;      assign ifb.hit = hit;

  fighter_anim_ctrl #(.FRAME_DIV(2), .STEP(4), .X_MIN(0), .X_MAX(520),
                      .X_INIT(100), .Y_GROUND(300))
    dut_a (.vga_clk(vga_clk), .reset_n(reset_n), .bus(ifa.slave));

  fighter_anim_ctrl #(.FRAME_DIV(2), .STEP(4), .X_MIN(0), .X_MAX(520),
                      .X_INIT(2), .Y_GROUND(300))
    dut_b (.vga_clk(vga_clk), .reset_n(reset_n), .bus(ifb.slave));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_tick();
    @(negedge vga_clk) vsync = 1'b0;
    repeat (3) @(negedge vga_clk);
    vsync = 1'b1;
    repeat (3) @(negedge vga_clk);
  endtask

  task automatic pulse_hit();
    @(negedge vga_clk) hit = 1'b1;
    @(negedge vga_clk) hit = 1'b0;
    repeat (2) @(negedge vga_clk);
  endtask

  task automatic apply_reset();
    @(negedge vga_clk) reset_n = 1'b0;
    @(negedge vga_clk) reset_n = 1'b1;
    @(negedge vga_clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp1[8] = '{0, 1, 1, 2, 2, 3, 3, 0};
    int exp4[6] = '{0, 0, 1, 1, 2, 2};
    int exp5[3] = '{0, 1, 1};
    reset_n = 1'b0;
    vsync = 1'b1; bl = 1'b0; br = 1'b0; bp = 1'b0; bk = 1'b0; hit = 1'b0;
    repeat (3) @(negedge vga_clk);

    check("rst_sel",    ifa.sprite_sel, 0);
    check("rst_frame",  ifa.frame_idx, 0);
    check("rst_busy",   ifa.busy, 0);
    check("rst_facing", ifa.facing_left, 0);
    check("rst_x",      ifa.RyuX, 100);
    check("rst_y",      ifa.RyuY, 300);
    check("rst_x_b",    ifb.RyuX, 2);
    @(negedge vga_clk) reset_n = 1'b1;
    @(negedge vga_clk);

    // Idle loop with FRAME_DIV=2
    for (int i = 0; i < 8; i++) begin
      do_tick();
      check($sformatf("idle_frame%0d", i), ifa.frame_idx, exp1[i]);
    end
    check("idle_sel", ifa.sprite_sel, 0);
    check("idle_x",   ifa.RyuX, 100);

    // Walk right, then into the right clamp
    br = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_tick();
      check($sformatf("right_x%0d", i), ifa.RyuX, 104 + 4 * i);
      check($sformatf("right_xb%0d", i), ifb.RyuX, 6 + 4 * i);
    end
    check("right_sel",    ifa.sprite_sel, 1);
    check("right_facing", ifa.facing_left, 0);
    for (int k = 6; k <= 129; k++) do_tick();
    check("right_b518", ifb.RyuX, 518);
    check("right_a520", ifa.RyuX, 520);
    do_tick();
    check("right_b_clamp", ifb.RyuX, 520);
    do_tick();
    check("right_b_hold", ifb.RyuX, 520);
    check("right_a_hold", ifa.RyuX, 520);
    br = 1'b0;

    // Walk left into the left clamp, release keeps facing
    apply_reset();
    bl = 1'b1;
    do_tick();
    check("left_b0",     ifb.RyuX, 0);
    check("left_a96",    ifa.RyuX, 96);
    check("left_facing", ifb.facing_left, 1);
    check("left_sel",    ifa.sprite_sel, 1);
    do_tick();
    check("left_b_hold", ifb.RyuX, 0);
    check("left_a92",    ifa.RyuX, 92);
    bl = 1'b0;
    do_tick();
    check("rel_sel",    ifa.sprite_sel, 0);
    check("rel_facing", ifa.facing_left, 1);
    check("rel_x",      ifa.RyuX, 92);

    // Both directions held is not a walk
    bl = 1'b1; br = 1'b1;
    do_tick();
    check("both_sel",    ifa.sprite_sel, 0);
    check("both_x",      ifa.RyuX, 92);
    check("both_facing", ifa.facing_left, 1);
    bl = 1'b0; br = 1'b0;

    // Punch plays once, left ignored while busy
    apply_reset();
    bp = 1'b1; bl = 1'b1;
    for (int i = 0; i < 6; i++) begin
      do_tick();
      bp = 1'b0;
      check($sformatf("punch_sel%0d", i),   ifa.sprite_sel, 2);
      check($sformatf("punch_busy%0d", i),  ifa.busy, 1);
      check($sformatf("punch_frame%0d", i), ifa.frame_idx, exp4[i]);
      check($sformatf("punch_x%0d", i),     ifa.RyuX, 100);
    end
    do_tick();
    check("after_punch_sel",    ifa.sprite_sel, 1);
    check("after_punch_busy",   ifa.busy, 0);
    check("after_punch_x",      ifa.RyuX, 96);
    check("after_punch_facing", ifa.facing_left, 1);
    bl = 1'b0;

    // Hit mid-punch, then restart of hit-stun
    apply_reset();
    bp = 1'b1;
    do_tick();
    bp = 1'b0;
    do_tick();
    do_tick();
    check("mid_punch_frame", ifa.frame_idx, 1);
    pulse_hit();
    do_tick();
    check("hit_sel",   ifa.sprite_sel, 4);
    check("hit_frame", ifa.frame_idx, 0);
    check("hit_busy",  ifa.busy, 1);
    for (int i = 0; i < 3; i++) begin
      do_tick();
      check($sformatf("stun_sel%0d", i),   ifa.sprite_sel, 4);
      check($sformatf("stun_frame%0d", i), ifa.frame_idx, exp5[i]);
    end
    do_tick();
    check("stun_end_sel",  ifa.sprite_sel, 0);
    check("stun_end_busy", ifa.busy, 0);
    pulse_hit();
    do_tick();
    do_tick();
    do_tick();
    check("stun2_frame1", ifa.frame_idx, 1);
    pulse_hit();
    do_tick();
    check("restun_sel",   ifa.sprite_sel, 4);
    check("restun_frame", ifa.frame_idx, 0);

    // Asynchronous reset mid-kick
    apply_reset();
    bl = 1'b1;
    do_tick();
    do_tick();
    bl = 1'b0; bk = 1'b1;
    do_tick();
    bk = 1'b0;
    check("kick_sel", ifa.sprite_sel, 3);
    check("kick_x",   ifa.RyuX, 92);
    do_tick();
    do_tick();
    check("kick_frame", ifa.frame_idx, 1);
    @(posedge vga_clk);
    #3 reset_n = 1'b0;
    #1;
    check("arst_sel",    ifa.sprite_sel, 0);
    check("arst_frame",  ifa.frame_idx, 0);
    check("arst_busy",   ifa.busy, 0);
    check("arst_facing", ifa.facing_left, 0);
    check("arst_x",      ifa.RyuX, 100);
    @(negedge vga_clk) reset_n = 1'b1;
    @(negedge vga_clk);

    // Hit in the same cycle as the tick
    @(negedge vga_clk) vsync = 1'b0;
    @(negedge vga_clk);
    @(negedge vga_clk) hit = 1'b1;
    @(negedge vga_clk) hit = 1'b0;
    vsync = 1'b1;
    repeat (3) @(negedge vga_clk);
    check("same_sel",   ifa.sprite_sel, 4);
    check("same_frame", ifa.frame_idx, 0);
    do_tick();
    do_tick();
    check("same_latch_clear", ifa.frame_idx, 1);
    do_tick();
    do_tick();
    check("same_end_sel", ifa.sprite_sel, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fighter_anim_ctrl.md
# fighter_anim_ctrl

Per-fighter animation and motion sequencer that drives the sprite renderers. Once per video frame it reads the player buttons and the collision hit pulse. From these it advances a state machine (idle, walk, punch, kick, hit-stun) and produces the sprite bank select, animation frame index, facing direction and the top-left position RyuX/RyuY. Those outputs are consumed by the left/right sprite ROM address generators and the palette mux. All outputs are registered and change only in the cycle after a frame tick, so they are stable for the whole visible field.

## Interface
- FRAME_DIV, 6: frame ticks per animation-frame advance (≥1).
- STEP, 4: pixels moved per frame tick while walking.
- X_MIN, 0: leftmost legal RyuX.
- X_MAX, 520: rightmost legal RyuX (640 − 120 sprite width).
- X_INIT, 100: RyuX after reset.
- Y_GROUND, 300: constant RyuY.
- vga_clk  in  1  pixel clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- vsync  in  1  VGA vsync, active-low, asynchronous to logic use.
- btn_left, btn_right, btn_punch, btn_kick  in  1  level inputs, already debounced.
- hit  in  1  one-cycle pulse from collision logic, any cycle.
- sprite_sel  out  3  0 idle, 1 walk, 2 punch, 3 kick, 4 hit.
- frame_idx  out  2  animation frame within the current sequence.
- facing_left  out  1  selects the left-facing ROM when 1.
- RyuX, RyuY  out  10  sprite top-left position.
- busy  out  1  1 in PUNCH, KICK or HITSTUN.

## Operation
- Reset (async assert, sync release) sets:
  - state IDLE, sprite_sel 0, frame_idx 0, busy 0, facing_left 0.
  - RyuX = X_INIT, RyuY = Y_GROUND.
  - div counter 0, hit latch 0, synchronizer flops 1.
- vsync passes through 2 flops. A falling edge of the synchronized signal produces `tick`, one vga_clk wide.
- hit is latched (sticky) in any cycle. The latch clears on the tick that consumes it. A hit arriving in the same cycle as a tick is consumed by that tick.
- On each tick, the next state is chosen in this priority order:
  1. hit latch set → HITSTUN. This applies from any state, including restarting HITSTUN.
  2. busy state not yet finished → stay.
  3. btn_punch → PUNCH.
  4. btn_kick → KICK.
  5. exactly one of btn_left/btn_right → WALK.
  6. otherwise → IDLE.
- Sequence lengths:
  - IDLE and WALK loop over 4 frames.
  - PUNCH and KICK play 3 frames once.
  - HITSTUN plays 2 frames once.
- A one-shot state is finished when frame_idx equals its last frame and the div counter reaches FRAME_DIV−1. It then takes the priority evaluation above on that tick.
- Entering a different state (or re-entering HITSTUN) resets frame_idx and the div counter to 0.
- Otherwise, each tick increments the div counter. When it reaches FRAME_DIV−1 it wraps to 0 and frame_idx advances; looping states wrap from 3 to 0.
- In WALK, each tick moves RyuX by STEP, with saturating clamps:
  - Left: if RyuX < X_MIN+STEP then X_MIN, else RyuX−STEP.
  - Right: if RyuX > X_MAX−STEP then X_MAX, else RyuX+STEP.
- Movement uses 11-bit intermediates with no wrap.
- Movement is applied on the same tick that enters WALK.
- facing_left updates only on ticks where the WALK condition holds: 1 for left, 0 for right. It holds through attacks and hit-stun.
- Both direction buttons held is not a walk input: it leads to IDLE, with no movement and no facing change.
- Buttons are ignored while busy, except that a hit always wins.
- RyuY is constant at Y_GROUND.

## Timing
- Outputs update in the cycle after `tick`.
- Latency from the vsync falling edge to outputs: 3 vga_clk cycles (2 sync flops plus 1 register).
- Between ticks, all outputs are held constant. No output changes during active video.
- Reset asserted mid-sequence takes effect immediately. After release, the first tick evaluates from IDLE.

## Test plan
1. FRAME_DIV=2, no buttons, 8 ticks → sprite_sel 0, frame_idx sequence 0,0,1,1,2,2,3,3, then 0; RyuX stays 100.
2. btn_right held for 5 ticks from X=100 → sprite_sel 1, facing_left 0, RyuX 104,108,112,116,120; with X_MAX=520 starting at 518, RyuX is 520 and stays 520.
3. btn_left held from X=2, STEP=4 → RyuX 0 and holds 0; facing_left 1; releasing → IDLE, facing_left stays 1.
4. btn_punch pulsed for 1 tick, FRAME_DIV=2 → sprite_sel 2 and busy 1 for exactly 6 ticks with frame_idx 0,0,1,1,2,2; btn_left held meanwhile gives no motion; then WALK on the next tick.
5. hit pulse mid-PUNCH (frame_idx 1), between ticks → next tick sprite_sel 4 and frame_idx 0; HITSTUN lasts 4 ticks; a second hit during HITSTUN restarts it at frame_idx 0.
6. reset_n low mid-KICK, asynchronously → outputs go to reset values immediately; hit and tick in the same cycle → that tick enters HITSTUN and the latch is clear afterwards.
